// File: rtl/led_activity_ctrl.sv
// Multi-channel LED activity driver: stretches single-cycle event pulses into
// visible on-times with one-shot, retrigger, blink-with-gap and steady modes.
module led_activity_ctrl #(
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned ON_TIME    = 62_500_000,
    parameter int unsigned OFF_TIME   = 31_250_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CH_NUM-1:0] iv_pulse,
    input  logic [CH_NUM-1:0] iv_ch_en,
    input  logic [1:0]        iv_mode,
    output logic [CH_NUM-1:0] ov_led,
    output logic [CH_NUM-1:0] ov_busy
);

    // state  | meaning
    // S_IDLE | LED unlit, waiting for an event pulse
    // S_ON   | LED lit, counting ON_TIME cycles
    // S_GAP  | BLINK only: forced-off gap, counting OFF_TIME cycles
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] M_ONESHOT = 2'd0;
    localparam logic [1:0] M_RETRIG  = 2'd1;
    localparam logic [1:0] M_BLINK   = 2'd2;
    localparam logic [1:0] M_STEADY  = 2'd3;

    localparam logic [CNT_W-1:0] ON_TC  = CNT_W'(ON_TIME - 1);
    localparam logic [CNT_W-1:0] OFF_TC = CNT_W'(OFF_TIME - 1);

    // Reset asserts asynchronously but is released in step with i_clk.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_ch
        state_t           r_state, w_state_nxt;
        logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
        logic             r_pend, w_pend_nxt;
        logic             w_lit_nxt;
        logic             r_led, r_busy;
        logic             w_on_tc, w_off_tc;

        assign w_on_tc  = (r_cnt == ON_TC);
        assign w_off_tc = (r_cnt == OFF_TC);

        always_ff @(posedge i_clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_pend  <= 1'b0;
                r_led   <= ACTIVE_LOW;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_pend  <= w_pend_nxt;
                r_led   <= w_lit_nxt ^ ACTIVE_LOW;
                r_busy  <= (w_state_nxt != S_IDLE);
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_pend_nxt  = r_pend;
            w_lit_nxt   = 1'b0;
            if (!iv_ch_en[g]) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_pend_nxt  = 1'b0;
            end else if (iv_mode == M_STEADY) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_pend_nxt  = 1'b0;
                w_lit_nxt   = 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_cnt_nxt  = '0;
                        w_pend_nxt = 1'b0;
                        if (iv_pulse[g]) begin
                            w_state_nxt = S_ON;
                            w_lit_nxt   = 1'b1;
                        end
                    end
                    S_ON: begin
                        w_lit_nxt = 1'b1;
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (iv_mode == M_BLINK && iv_pulse[g]) w_pend_nxt = 1'b1;
                        // A retrigger pulse beats the terminal count on the same edge.
                        if (iv_mode == M_RETRIG && iv_pulse[g]) begin
                            w_cnt_nxt = '0;
                        end else if (w_on_tc) begin
                            w_cnt_nxt = '0;
                            w_lit_nxt = 1'b0;
                            if (iv_mode == M_BLINK) begin
                                w_state_nxt = S_GAP;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_pend_nxt  = 1'b0;
                            end
                        end
                    end
                    S_GAP: begin
                        if (iv_mode != M_BLINK) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                            w_pend_nxt  = 1'b0;
                        end else if (w_off_tc) begin
                            w_cnt_nxt  = '0;
                            w_pend_nxt = 1'b0;
                            if (r_pend || iv_pulse[g]) begin
                                w_state_nxt = S_ON;
                                w_lit_nxt   = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                            if (iv_pulse[g]) w_pend_nxt = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_pend_nxt  = 1'b0;
                    end
                endcase
            end
        end

        assign ov_led[g]  = r_led;
        assign ov_busy[g] = r_busy;
    end

endmodule
